// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   state_t : arbiter FSM encoding (IDLE, EXEC, DONE)
//   OP_*    : 3-bit ALU operation select codes
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 16-bit combinational ALU shared by both requesters.
//   i_op : operation select (OP_* codes)
//   i_a  : operand a
//   i_b  : operand b
//   o_y  : result, arithmetic wraps modulo 2^16
module alu
    import alu_arb_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);

    logic        w_sub;
    logic [15:0] w_b_sel;
    logic [15:0] w_sum;

    // One adder serves add, sub and the reserved code: subtraction is
    // a + ~b + 1, and the carry/borrow out is simply dropped.
    assign w_sub   = (i_op == OP_SUB);
    assign w_b_sel = w_sub ? ~i_b : i_b;
    assign w_sum   = i_a + w_b_sel + 16'(w_sub);

    always_comb begin
        o_y = w_sum;
        case (i_op)
            OP_AND:   o_y = i_a & i_b;
            OP_OR:    o_y = i_a | i_b;
            OP_XOR:   o_y = i_a ^ i_b;
            OP_PASSA: o_y = i_a;
            OP_PASSB: o_y = i_b;
            default:  o_y = w_sum;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a shared ALU.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req0/req1          : level requests
//   op0/op1, a0/b0/a1/b1 : per-requester operation and operands
//   gnt0/gnt1          : pulse during EXEC, operands captured
//   done0/done1        : pulse during DONE, result valid
//   result, zero, err  : registered result, result==0, reserved op executed
//   busy               : FSM not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | sample requests; on any request capture winner and go EXEC
// EXEC  | ALU runs on captured operands; gnt of winner high
// DONE  | result/zero/err valid; done of winner high; back to IDLE
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        zero,
    output logic        err,
    output logic        busy
);

    state_t      r_state;
    state_t      w_next;
    logic        r_prio;
    logic        r_win;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;
    logic        r_zero;
    logic        r_err;

    logic        w_win;
    logic        w_capture;
    logic [15:0] w_alu_y;

    // Lone request always wins; on contention r_prio names the winner.
    assign w_win = (req0 && req1) ? r_prio : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_capture = 1'b1;
                    w_next    = EXEC;
                end
            end
            EXEC: begin
                gnt0   = ~r_win;
                gnt1   = r_win;
                w_next = DONE;
            end
            DONE: begin
                done0  = ~r_win;
                done1  = r_win;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // Operand capture plus round-robin update: the loser of this grant
    // gets priority next time, contention or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_INIT;
            r_win  <= 1'b0;
            r_op   <= OP_ADD;
            r_a    <= '0;
            r_b    <= '0;
        end else if (w_capture) begin
            r_prio <= ~w_win;
            r_win  <= w_win;
            r_op   <= w_win ? op1 : op0;
            r_a    <= w_win ? a1 : a0;
            r_b    <= w_win ? b1 : b0;
        end
    end

    alu u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_result <= w_alu_y;
            r_zero   <= (w_alu_y == 16'h0000);
            r_err    <= (r_op == OP_RSVD);
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign err    = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] result;
    logic        zero, err, busy;

    int n_cmp;
    int n_bad;

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .zero   (zero),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #2;
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy, zero, err} !== 7'b0 || result !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got flags=%b result=%h, want flags=0000000 result=0000",
                     {gnt0, gnt1, done0, done1, busy, zero, err}, result);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    // REQ: req0 add 0x7FFF + 0x0001 -> 0x8000
    task automatic test_single0();
        op0 = 3'b000; a0 = 16'h7FFF; b0 = 16'h0001; req0 = 1;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10001) begin
            n_bad++;
            $display("FAIL single0_exec: gnt0,gnt1,done0,done1,busy=%b want 10001",
                     {gnt0, gnt1, done0, done1, busy});
        end
        req0 = 0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b00101) begin
            n_bad++;
            $display("FAIL single0_done: flags=%b want 00101", {gnt0, gnt1, done0, done1, busy});
        end
        n_cmp++;
        if (result !== 16'h8000 || zero !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL single0_result: result=%h zero=%b err=%b want 8000 0 0", result, zero, err);
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b00000 || result !== 16'h8000) begin
            n_bad++;
            $display("FAIL single0_idle_hold: flags=%b result=%h want 00000 8000",
                     {gnt0, gnt1, done0, done1, busy}, result);
        end
    endtask

    // REQ: req1 sub 5 - 5 -> 0, zero=1
    task automatic test_single1();
        op1 = 3'b001; a1 = 16'h0005; b1 = 16'h0005; req1 = 1;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b01001) begin
            n_bad++;
            $display("FAIL single1_exec: flags=%b want 01001", {gnt0, gnt1, done0, done1, busy});
        end
        req1 = 0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0001 || result !== 16'h0000 || zero !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL single1_done: flags=%b result=%h zero=%b err=%b want 0001 0000 1 0",
                     {gnt0, gnt1, done0, done1}, result, zero, err);
        end
        tick();
    endtask

    // REQ: both held from reset with PRIO_INIT=0 -> grants 0,1,0,1
    task automatic test_back_to_back();
        logic        w;
        logic [3:0]  exp_flags;
        logic [15:0] exp_res;
        rst_n = 0;
        #1 rst_n = 1;
        exp_res = 16'h0000;
        op0 = 3'b000; a0 = 16'h0001; b0 = 16'h0002;
        op1 = 3'b100; a1 = 16'h00F0; b1 = 16'h0FF0;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            w = ((i / 3) % 2) == 1;
            case (i % 3)
                0: exp_flags = w ? 4'b0100 : 4'b1000;
                1: begin
                    exp_flags = w ? 4'b0001 : 4'b0010;
                    exp_res   = w ? 16'h0F00 : 16'h0003;
                end
                default: exp_flags = 4'b0000;
            endcase
            if (i == 11) begin
                req0 = 0; req1 = 0;
            end
            n_cmp++;
            if ({gnt0, gnt1, done0, done1} !== exp_flags) begin
                n_bad++;
                $display("FAIL b2b_flags[%0d]: gnt0,gnt1,done0,done1=%b want %b",
                         i, {gnt0, gnt1, done0, done1}, exp_flags);
            end
            n_cmp++;
            if (result !== exp_res) begin
                n_bad++;
                $display("FAIL b2b_result[%0d]: result=%h want %h", i, result, exp_res);
            end
            n_cmp++;
            if ((gnt0 && gnt1) || (done0 && done1)) begin
                n_bad++;
                $display("FAIL b2b_exclusive[%0d]: gnt=%b%b done=%b%b want no overlap",
                         i, gnt0, gnt1, done0, done1);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: busy=%b want 0", busy);
        end
    endtask

    // REQ: reserved op computes add and flags err; next op clears err
    task automatic test_reserved();
        op0 = 3'b111; a0 = 16'hFFFF; b0 = 16'h0002; req0 = 1;
        tick();
        req0 = 0;
        tick();
        n_cmp++;
        if (done0 !== 1'b1 || result !== 16'h0001 || err !== 1'b1 || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL rsvd_done: done0=%b result=%h err=%b zero=%b want 1 0001 1 0",
                     done0, result, err, zero);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL rsvd_hold: err=%b want 1", err);
        end
        op0 = 3'b010; req0 = 1;
        tick();
        req0 = 0;
        tick();
        n_cmp++;
        if (done0 !== 1'b1 || result !== 16'h0002 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL and_after_rsvd: done0=%b result=%h err=%b want 1 0002 0", done0, result, err);
        end
        tick();
    endtask

    // REQ: live operand changes during EXEC must not leak into the result
    task automatic test_capture();
        op0 = 3'b101; a0 = 16'hABCD; b0 = 16'h5555; req0 = 1;
        tick();
        a0 = 16'h1234; op0 = 3'b110; b0 = 16'h0000; req0 = 0;
        tick();
        n_cmp++;
        if (done0 !== 1'b1 || result !== 16'hABCD) begin
            n_bad++;
            $display("FAIL capture: done0=%b result=%h want 1 ABCD", done0, result);
        end
        tick();
    endtask

    // REQ: reset mid-EXEC clears everything, no done, prio back to init
    task automatic test_reset_mid();
        op0 = 3'b000; a0 = 16'h0010; b0 = 16'h0020; req0 = 1;
        tick();
        req0 = 0;
        n_cmp++;
        if (gnt0 !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_exec: gnt0=%b busy=%b want 1 1", gnt0, busy);
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, busy, zero, err} !== 7'b0 || result !== 16'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: flags=%b result=%h want 0000000 0000",
                     {gnt0, gnt1, done0, done1, busy, zero, err}, result);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({done0, done1, busy} !== 3'b000) begin
                n_bad++;
                $display("FAIL rstmid_nodone[%0d]: done0,done1,busy=%b want 000", i, {done0, done1, busy});
            end
        end
        op1 = 3'b000; a1 = 16'h0001; b1 = 16'h0001;
        req0 = 1; req1 = 1;
        tick();
        req0 = 0; req1 = 0;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_prio: gnt0,gnt1=%b want 10", {gnt0, gnt1});
        end
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single0();
        test_single1();
        test_back_to_back();
        test_reserved();
        test_capture();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
